// File: rtl/piso32_tx_pkg.sv
// Serial-link package: state encoding and default word length shared by
// the serial transmitter and its serial-in receiver.
package piso32_tx_pkg;

   // Default word length for both ends of the link
   localparam int unsigned LINK_WIDTH = 32;

   // Transmitter FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2
   } link_state_t;

endpackage

// File: rtl/piso32_tx.sv
// Parallel-in, serial-out transmitter. Accepts a word on LOAD/READY and
// sends it MSB first, one bit per CLK, qualified by SHIFT_EN. Every output
// comes from registered state, so no input reaches an output combinationally.
module piso32_tx
   import piso32_tx_pkg::*;
#(
   parameter int unsigned WIDTH = LINK_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             LOAD,
   output logic             READY,
   input  logic             ABORT,
   output logic             D_OUT,
   output logic             SHIFT_EN,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   link_state_t      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State, shift register and bit counter; async active-high reset
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: load, shift/count, abort and frame completion
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            // ABORT alongside LOAD refuses the word
            if (LOAD && !ABORT) begin
               shreg_d = DATA_IN;
               cnt_d   = CNT_W'(WIDTH - 1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ABORT) begin
               // Abort wins even on the last bit: no FIN, no DONE
               shreg_d = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               shreg_d = shreg_q << 1;
               if (cnt_q == '0) begin
                  // Hold the counter at zero rather than wrapping
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      READY    = (state_q == ST_IDLE);
      BUSY     = (state_q == ST_SHIFT);
      SHIFT_EN = (state_q == ST_SHIFT);
      DONE     = (state_q == ST_FIN);
      D_OUT    = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
   end

endmodule

// File: tb/tb_piso32_tx.sv
// Directed bench for piso32_tx: a 32-bit and an 8-bit instance, each
// feeding a serial-in receive register that shifts only on SHIFT_EN.
module tb_piso32_tx;

   logic        CLK;
   logic        RESET;

   logic [31:0] data32;
   logic        load32, abort32;
   logic        ready32, dout32, en32, busy32, done32;

   logic [7:0]  data8;
   logic        load8, abort8;
   logic        ready8, dout8, en8, busy8, done8;

   logic [31:0] rx32;
   logic [7:0]  rx8;

   int checks;
   int failures;

   piso32_tx #(.WIDTH(32)) u_dut32 (
      .CLK      (CLK),
      .RESET    (RESET),
      .DATA_IN  (data32),
      .LOAD     (load32),
      .READY    (ready32),
      .ABORT    (abort32),
      .D_OUT    (dout32),
      .SHIFT_EN (en32),
      .BUSY     (busy32),
      .DONE     (done32)
   );

   piso32_tx #(.WIDTH(8)) u_dut8 (
      .CLK      (CLK),
      .RESET    (RESET),
      .DATA_IN  (data8),
      .LOAD     (load8),
      .READY    (ready8),
      .ABORT    (abort8),
      .D_OUT    (dout8),
      .SHIFT_EN (en8),
      .BUSY     (busy8),
      .DONE     (done8)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Receive registers: shift MSB-first stream in at the bottom on enabled cycles
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rx32 <= '0;
         rx8  <= '0;
      end else begin
         if (en32) rx32 <= {rx32[30:0], dout32};
         if (en8)  rx8  <= {rx8[6:0], dout8};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts on the negedge of the first SHIFT cycle; ends on the negedge after FIN
   task automatic collect32(input string tag, input logic [31:0] exp);
      logic [31:0] bits;
      int          en;
      bits = '0;
      en   = 0;
      for (int i = 0; i < 32; i++) begin
         if (en32) en++;
         bits = {bits[30:0], dout32};
         @(negedge CLK);
      end
      chk({tag, " bits"}, 64'(bits), 64'(exp));
      chk({tag, " en_count"}, 64'(en), 64'd32);
      chk({tag, " done_fin"}, 64'(done32), 64'd1);
      chk({tag, " ready_fin"}, 64'(ready32), 64'd0);
      chk({tag, " rx"}, 64'(rx32), 64'(exp));
      @(negedge CLK);
      chk({tag, " done_after"}, 64'(done32), 64'd0);
      chk({tag, " ready_after"}, 64'(ready32), 64'd1);
   endtask

   task automatic send32(input string tag, input logic [31:0] w);
      data32 = w;
      load32 = 1'b1;
      @(negedge CLK);
      load32 = 1'b0;
      data32 = ~w;
      chk({tag, " ready_low"}, 64'(ready32), 64'd0);
      chk({tag, " busy"}, 64'(busy32), 64'd1);
   endtask

   initial begin
      int en;
      logic [7:0] bits8;
      checks   = 0;
      failures = 0;
      RESET    = 1'b1;
      data32   = '0;
      load32   = 1'b0;
      abort32  = 1'b0;
      data8    = '0;
      load8    = 1'b0;
      abort8   = 1'b0;

      // Reset values
      @(negedge CLK);
      chk("rst ready", 64'(ready32), 64'd1);
      chk("rst dout", 64'(dout32), 64'd0);
      chk("rst en", 64'(en32), 64'd0);
      chk("rst busy", 64'(busy32), 64'd0);
      chk("rst done", 64'(done32), 64'd0);
      chk("rst ready8", 64'(ready8), 64'd1);
      RESET = 1'b0;
      @(negedge CLK);

      // 1: single word
      send32("t1", 32'h8000_0001);
      chk("t1 first_bit", 64'(dout32), 64'd1);
      collect32("t1", 32'h8000_0001);

      // 2: back-to-back with LOAD held; DATA_IN change after accept is ignored
      data32 = 32'hDEAD_BEEF;
      load32 = 1'b1;
      @(negedge CLK);
      data32 = 32'h1234_5678;
      collect32("t2a", 32'hDEAD_BEEF);
      @(negedge CLK);
      load32 = 1'b0;
      data32 = 32'h0;
      chk("t2 second_accept", 64'(busy32), 64'd1);
      collect32("t2b", 32'h1234_5678);

      // 3: abort in 10th SHIFT cycle
      send32("t3", 32'hFFFF_FFFF);
      en = 0;
      for (int i = 1; i < 10; i++) begin
         if (en32) en++;
         @(negedge CLK);
      end
      if (en32) en++;
      abort32 = 1'b1;
      @(negedge CLK);
      abort32 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (en32) en++;
         chk("t3 no_done", 64'(done32), 64'd0);
         chk("t3 ready", 64'(ready32), 64'd1);
         @(negedge CLK);
      end
      chk("t3 en_count", 64'(en), 64'd10);
      send32("t3b", 32'h0000_A5A5);
      collect32("t3b", 32'h0000_A5A5);

      // 4: abort on the last bit
      send32("t4", 32'h0F0F_0F0F);
      for (int i = 1; i < 32; i++) @(negedge CLK);
      chk("t4 last_en", 64'(en32), 64'd1);
      abort32 = 1'b1;
      @(negedge CLK);
      abort32 = 1'b0;
      chk("t4 no_done", 64'(done32), 64'd0);
      chk("t4 en", 64'(en32), 64'd0);
      chk("t4 busy", 64'(busy32), 64'd0);
      chk("t4 ready", 64'(ready32), 64'd1);
      @(negedge CLK);
      chk("t4 no_done2", 64'(done32), 64'd0);

      // 5: async reset mid-frame, between edges
      send32("t5", 32'hFFFF_FFFF);
      @(negedge CLK);
      @(negedge CLK);
      chk("t5 pre_dout", 64'(dout32), 64'd1);
      #2;
      RESET = 1'b1;
      #1;
      chk("t5 dout", 64'(dout32), 64'd0);
      chk("t5 en", 64'(en32), 64'd0);
      chk("t5 busy", 64'(busy32), 64'd0);
      chk("t5 ready", 64'(ready32), 64'd1);
      chk("t5 done", 64'(done32), 64'd0);
      RESET = 1'b0;
      @(negedge CLK);
      chk("t5 done_after", 64'(done32), 64'd0);
      chk("t5 idle", 64'(busy32), 64'd0);

      // 5b: LOAD with ABORT in IDLE is refused
      data32  = 32'hFFFF_FFFF;
      load32  = 1'b1;
      abort32 = 1'b1;
      @(negedge CLK);
      chk("t5b ready", 64'(ready32), 64'd1);
      chk("t5b en", 64'(en32), 64'd0);
      @(negedge CLK);
      load32  = 1'b0;
      abort32 = 1'b0;
      chk("t5b en2", 64'(en32), 64'd0);
      chk("t5b busy", 64'(busy32), 64'd0);

      // 6: WIDTH = 8 instance
      data8 = 8'hA5;
      load8 = 1'b1;
      @(negedge CLK);
      load8 = 1'b0;
      data8 = 8'h00;
      chk("t6 ready_low", 64'(ready8), 64'd0);
      bits8 = '0;
      en    = 0;
      for (int i = 0; i < 8; i++) begin
         if (en8) en++;
         bits8 = {bits8[6:0], dout8};
         @(negedge CLK);
      end
      chk("t6 bits", 64'(bits8), 64'hA5);
      chk("t6 en_count", 64'(en), 64'd8);
      chk("t6 done", 64'(done8), 64'd1);
      chk("t6 rx", 64'(rx8), 64'hA5);
      @(negedge CLK);
      chk("t6 done_after", 64'(done8), 64'd0);
      chk("t6 ready", 64'(ready8), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
